// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int MIN_PAT_W = 2;
  localparam int MAX_PAT_W = 32;

  localparam logic [4:0] DEF_PATTERN = 5'b10110;

endpackage

// File: rtl/seq_shift_hist.sv
// History shift register for the detector.
// The newest bit enters at bit 0, and older bits move toward the MSB.
// A synchronous clear takes priority over a shift.
module seq_shift_hist #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_shift,
  input  logic         i_clr,
  input  logic         i_bit,
  output logic [W-1:0] o_hist
);

  logic [W-1:0] r_hist;

  // Valid-gated shift; the truncating cast drops the oldest bit (also works for W==1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_hist <= '0;
    else if (i_clr)   r_hist <= '0;
    else if (i_shift) r_hist <= W'({r_hist, i_bit});
  end

  assign o_hist = r_hist;

endmodule

// File: rtl/param_seq_detector.sv
// Parametrised Mealy serial-pattern detector.
// The pattern is loadable at run time, and overlap mode is selected at run time.
// Optional feature: define DET_CNT_EN to build the saturating hit counter.
// Without DET_CNT_EN, det_cnt reads 0 and cnt_clr is ignored.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_seq,
  input  logic             overlap_en,
  input  logic             pat_wr,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             det_out,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int FILL_W = $clog2(PAT_W);

  state_t             r_state, w_state_nxt;
  logic [FILL_W-1:0]  r_fill, w_fill_nxt;
  logic [PAT_W-1:0]   r_pat;
  logic [PAT_W-2:0]   w_hist;
  logic               w_shift, w_hclr, w_match, w_det;

  seq_shift_hist #(.W(PAT_W-1)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_clr   (w_hclr),
    .i_bit   (in_seq),
    .o_hist  (w_hist)
  );

  assign w_match = ({w_hist, in_seq} == r_pat);

  // Pattern register: loads on pat_wr and otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_pat <= PATTERN;
    else if (pat_wr) r_pat <= pat_in;
  end

  // FSM state and fill-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Next state, history control and Mealy detect.
  // A pattern load overrides any incoming bit.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_shift     = 1'b0;
    w_hclr      = 1'b0;
    w_det       = 1'b0;
    if (pat_wr) begin
      w_state_nxt = FILL;
      w_fill_nxt  = '0;
      w_hclr      = 1'b1;
    end else if (in_valid) begin
      w_shift = 1'b1;
      case (r_state)
        FILL: begin
          if (r_fill == FILL_W'(PAT_W-2)) begin
            w_fill_nxt  = FILL_W'(PAT_W-1);
            w_state_nxt = ARMED;
          end else begin
            w_fill_nxt = r_fill + FILL_W'(1);
          end
        end
        ARMED: begin
          if (w_match) begin
            w_det = 1'b1;
            // In non-overlap mode, the next hit needs a full set of fresh bits
            if (!overlap_en) begin
              w_fill_nxt  = '0;
              w_state_nxt = FILL;
            end
          end
        end
        default: begin
          w_state_nxt = FILL;
          w_fill_nxt  = '0;
        end
      endcase
    end
  end

  assign det_out = w_det & ~rst;

`ifdef DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating hit counter; a clear beats a same-cycle detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_cnt <= '0;
    else if (cnt_clr)            r_cnt <= '0;
    else if (det_out && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign det_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign det_cnt          = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Randomised plus directed bench for param_seq_detector.
// The reference model keeps the list of fresh bits received since the last restart.
// It reports a hit when the newest PAT_W of those bits equal the current pattern.
module tb_param_seq_detector;

  localparam int P = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 0, in_seq = 0, overlap_en = 0, pat_wr = 0, cnt_clr = 0;
  logic [P-1:0] pat_in = '0;
  logic         det_out;
  logic [7:0]   det_cnt;

  logic         v2 = 0, b2 = 0, clr2 = 0;
  logic         det2;
  logic [1:0]   cnt2;

  int total = 0;
  int bad   = 0;
  int hits  = 0;

  logic [P-1:0] m_pat;
  bit           mq[$];
  int           m_cnt;

  always #5 clk = ~clk;

  param_seq_detector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
    .overlap_en(overlap_en), .pat_wr(pat_wr), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .det_out(det_out), .det_cnt(det_cnt)
  );

  param_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_seq(b2),
    .overlap_en(1'b1), .pat_wr(1'b0), .pat_in(2'b00),
    .cnt_clr(clr2), .det_out(det2), .det_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef DET_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_pat = 5'b10110;
    mq.delete();
    m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; pat_wr = 0; cnt_clr = 0; v2 = 0; clr2 = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    hits = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic ov,
                      input logic wr = 0, input logic [P-1:0] pin = '0, input logic clr = 0);
    logic        e;
    logic [31:0] w;
    @(negedge clk);
    in_valid = v; in_seq = b; overlap_en = ov; pat_wr = wr; pat_in = pin; cnt_clr = clr;
    e = 1'b0;
    if (!wr && v && mq.size() >= P-1) begin
      w = '0;
      for (int i = mq.size() - (P-1); i < mq.size(); i++) w = {w[30:0], 1'(mq[i])};
      w = {w[30:0], b};
      e = (w[P-1:0] == m_pat);
    end
    #1 chk("det", det_out, e);
    if (det_out) hits++;
    @(posedge clk);
    if (wr) begin
      m_pat = pin;
      mq.delete();
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > 40) void'(mq.pop_front());
      if (e && !ov) mq.delete();
    end
`ifdef DET_CNT_EN
    if (clr) m_cnt = 0;
    else if (e && m_cnt < 255) m_cnt++;
`endif
    #1 chk("cnt", det_cnt, m_cnt);
  endtask

  task automatic stream(input logic [31:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov);
  endtask

  task automatic step2(input logic b, input logic clr, input logic e_det, input int e_cnt);
    @(negedge clk);
    v2 = 1; b2 = b; clr2 = clr;
    #1 chk("det2", det2, e_det);
    @(posedge clk);
    #1 chk("cnt2", cnt2, e_cnt);
  endtask

  initial begin
    model_reset();
    #1 chk("rst_det", det_out, 0);
    chk("rst_cnt", det_cnt, 0);
    do_reset();

    // 1: overlap, two hits
    stream(32'b10110110, 8, 1'b1);
    chk("t1_hits", hits, 2);
    chk("t1_cnt", det_cnt, cnt_exp(2));

    // 2: non-overlap, one hit
    do_reset();
    stream(32'b10110110, 8, 1'b0);
    chk("t2_hits", hits, 1);
    chk("t2_cnt", det_cnt, cnt_exp(1));

    // 3: valid gaps
    do_reset();
    stream(32'b101, 3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    stream(32'b10, 2, 1'b1);
    chk("t3_hits", hits, 1);

    // 4: pattern load mid-stream; the bit on the load cycle would have completed 10110
    do_reset();
    stream(32'b1011, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'b11100);
    chk("t4_wr_hits", hits, 0);
    stream(32'b11100, 5, 1'b0);
    chk("t4_new_hits", hits, 1);
    hits = 0;
    stream(32'b10110, 5, 1'b0);
    chk("t4_old_hits", hits, 0);

    // 5: saturation on the 2-bit instance, then clear against a detect
    do_reset();
    for (int k = 1; k <= 6; k++) step2(1'b1, 1'b0, k > 1, cnt_exp(k > 4 ? 3 : k - 1));
    step2(1'b1, 1'b1, 1'b1, 0);
    @(negedge clk); v2 = 0; clr2 = 0;

    // 6: async reset mid-pattern
    do_reset();
    stream(32'b101, 3, 1'b1);
    @(negedge clk);
    in_valid = 1; in_seq = 1; rst = 1;
    #1 chk("t6_det", det_out, 0);
    chk("t6_cnt", det_cnt, 0);
    @(negedge clk);
    rst = 0; in_valid = 0;
    model_reset(); hits = 0;
    stream(32'b0110, 4, 1'b1);
    chk("t6_tail_hits", hits, 0);
    stream(32'b10110, 5, 1'b1);
    chk("t6_full_hits", hits, 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic         wr;
      logic [P-1:0] pin;
      wr  = ($urandom_range(0, 49) == 0);
      pin = ($urandom_range(0, 1) == 0) ? 5'b11111 : P'($urandom);
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), wr, pin, ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
